// File: rtl/adder_pkg.sv
// Shared types and default widths for the adder / accumulator slice.
// Holds the accumulator state enum and the default sum and accumulator widths.
package adder_pkg;

    localparam int DEFAULT_SUM_W = 17;
    localparam int DEFAULT_ACC_W = 24;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

endpackage

// File: rtl/sat_add.sv
// ACC_W-bit unsigned adder reporting carry-out as overflow.
// Build macro SUM_ACCUM_SAT_EN clamps an overflowing result to all-ones instead of wrapping.
module sat_add
    import adder_pkg::*;
#(
    parameter int ACC_W = DEFAULT_ACC_W
) (
    input  logic [ACC_W-1:0] a,
    input  logic [ACC_W-1:0] b,
    output logic [ACC_W-1:0] sum,
    output logic             ovf
);

    logic [ACC_W:0] full_sum;

    assign full_sum = {1'b0, a} + {1'b0, b};
    assign ovf      = full_sum[ACC_W];

`ifdef SUM_ACCUM_SAT_EN
    // Once clamped, any further addition overflows again, so the result stays pinned at the maximum.
    assign sum = full_sum[ACC_W] ? {ACC_W{1'b1}} : full_sum[ACC_W-1:0];
`else
    assign sum = full_sum[ACC_W-1:0];
`endif

endmodule

// File: rtl/sum_accum.sv
// Block accumulator: sums BLOCK_LEN samples, then holds the total until downstream takes it.
// Saturating accumulation is selected with the SUM_ACCUM_SAT_EN build macro (wraps otherwise).
module sum_accum
    import adder_pkg::*;
#(
    parameter int SUM_W     = DEFAULT_SUM_W,
    parameter int ACC_W     = DEFAULT_ACC_W,
    parameter int BLOCK_LEN = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [SUM_W-1:0] in_sum,
    output logic             in_ready,
    output logic             out_valid,
    output logic [ACC_W-1:0] out_acc,
    output logic             out_ovf,
    input  logic             out_ready
);

    localparam int CNT_W = $clog2(BLOCK_LEN + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BLOCK_LEN - 1);

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;

    logic [ACC_W-1:0] add_sum;
    logic             add_ovf;
    logic             accept;
    logic             release_result;

    sat_add #(
        .ACC_W (ACC_W)
    ) u_sat_add (
        .a   (acc_q),
        .b   (ACC_W'(in_sum)),
        .sum (add_sum),
        .ovf (add_ovf)
    );

    assign in_ready       = (state_q == ACCUM);
    assign out_valid      = (state_q == HOLD);
    assign out_acc        = acc_q;
    assign out_ovf        = ovf_q;
    assign accept         = in_valid && in_ready;
    assign release_result = out_valid && out_ready;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= ACCUM;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    // The count reaches BLOCK_LEN only while holding and is cleared on release, so it never exceeds it.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        case (state_q)
            ACCUM: begin
                if (accept) begin
                    acc_d = add_sum;
                    ovf_d = ovf_q | add_ovf;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_CNT) begin
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (release_result) begin
                    state_d = ACCUM;
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                end
            end
            default: begin
                state_d = ACCUM;
            end
        endcase
    end

endmodule

// File: tb/tb_sum_accum.sv
// Directed self-checking bench for sum_accum: a default-width instance plus an ACC_W=18 instance
// for the overflow cases; expected totals are worked out by hand.
module tb_sum_accum;

    logic        clock;
    logic        reset;

    logic        in_valid, out_ready;
    logic [16:0] in_sum;
    logic        in_ready, out_valid, out_ovf;
    logic [23:0] out_acc;

    logic        in_valid18, out_ready18;
    logic [16:0] in_sum18;
    logic        in_ready18, out_valid18, out_ovf18;
    logic [17:0] out_acc18;

    int checks = 0;
    int errors = 0;

    sum_accum dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_sum    (in_sum),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_acc   (out_acc),
        .out_ovf   (out_ovf),
        .out_ready (out_ready)
    );

    sum_accum #(
        .SUM_W     (17),
        .ACC_W     (18),
        .BLOCK_LEN (4)
    ) dut18 (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid18),
        .in_sum    (in_sum18),
        .in_ready  (in_ready18),
        .out_valid (out_valid18),
        .out_acc   (out_acc18),
        .out_ovf   (out_ovf18),
        .out_ready (out_ready18)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Drive one cycle of inputs to the chosen instance, then settle 1 time unit past the rising edge.
    task automatic applyStimulus(input logic use18, input logic v, input logic [16:0] s, input logic r);
        if (use18) begin
            in_valid18  = v;
            in_sum18    = s;
            out_ready18 = r;
            in_valid    = 1'b0;
            in_sum      = '0;
            out_ready   = 1'b0;
        end else begin
            in_valid    = v;
            in_sum      = s;
            out_ready   = r;
            in_valid18  = 1'b0;
            in_sum18    = '0;
            out_ready18 = 1'b0;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    logic [31:0] exp18_mid;
    logic [31:0] exp18_final;

    initial begin
`ifdef SUM_ACCUM_SAT_EN
        exp18_mid   = 32'd262143;
        exp18_final = 32'd262143;
`else
        exp18_mid   = 32'd131069;
        exp18_final = 32'd262140;
`endif
        reset = 1'b0;
        applyStimulus(1'b0, 1'b1, 17'd55, 1'b1);
        checkOutput("reset_in_ready",  32'(in_ready),  32'd1);
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_out_acc",   32'(out_acc),   32'd0);
        checkOutput("reset_out_ovf",   32'(out_ovf),   32'd0);
        reset = 1'b1;

        // Basic block with out_ready high throughout.
        applyStimulus(1'b0, 1'b1, 17'd200,  1'b1);
        applyStimulus(1'b0, 1'b1, 17'd299,  1'b1);
        applyStimulus(1'b0, 1'b1, 17'd2173, 1'b1);
        checkOutput("basic_not_yet_valid", 32'(out_valid), 32'd0);
        applyStimulus(1'b0, 1'b1, 17'd0,    1'b1);
        checkOutput("basic_out_valid", 32'(out_valid), 32'd1);
        checkOutput("basic_out_acc",   32'(out_acc),   32'd2672);
        checkOutput("basic_out_ovf",   32'(out_ovf),   32'd0);
        checkOutput("basic_hold_in_ready", 32'(in_ready), 32'd0);
        applyStimulus(1'b0, 1'b0, 17'd0, 1'b1);
        checkOutput("basic_release_in_ready",  32'(in_ready),  32'd1);
        checkOutput("basic_release_out_valid", 32'(out_valid), 32'd0);

        // Backpressure: result held for three cycles while a sample of 5 is offered.
        applyStimulus(1'b0, 1'b1, 17'd1, 1'b0);
        applyStimulus(1'b0, 1'b1, 17'd2, 1'b0);
        applyStimulus(1'b0, 1'b1, 17'd3, 1'b0);
        applyStimulus(1'b0, 1'b1, 17'd4, 1'b0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b1, 17'd5, 1'b0);
            checkOutput("bp_out_valid", 32'(out_valid), 32'd1);
            checkOutput("bp_out_acc",   32'(out_acc),   32'd10);
            checkOutput("bp_out_ovf",   32'(out_ovf),   32'd0);
            checkOutput("bp_in_ready",  32'(in_ready),  32'd0);
        end
        applyStimulus(1'b0, 1'b0, 17'd0, 1'b1);
        checkOutput("bp_release_acc", 32'(out_acc), 32'd0);

        // Idle gaps inside a block.
        applyStimulus(1'b0, 1'b1, 17'd10, 1'b0);
        applyStimulus(1'b0, 1'b0, 17'd99, 1'b0);
        applyStimulus(1'b0, 1'b0, 17'd99, 1'b0);
        applyStimulus(1'b0, 1'b1, 17'd20, 1'b0);
        applyStimulus(1'b0, 1'b0, 17'd99, 1'b0);
        applyStimulus(1'b0, 1'b1, 17'd30, 1'b0);
        checkOutput("gap_partial_valid", 32'(out_valid), 32'd0);
        checkOutput("gap_partial_acc",   32'(out_acc),   32'd60);
        applyStimulus(1'b0, 1'b1, 17'd40, 1'b0);
        checkOutput("gap_out_valid", 32'(out_valid), 32'd1);
        checkOutput("gap_out_acc",   32'(out_acc),   32'd100);
        applyStimulus(1'b0, 1'b0, 17'd0, 1'b1);

        // Reset in mid-block discards the partial sum.
        applyStimulus(1'b0, 1'b1, 17'd7, 1'b0);
        applyStimulus(1'b0, 1'b1, 17'd9, 1'b0);
        reset = 1'b0;
        applyStimulus(1'b0, 1'b1, 17'd1, 1'b0);
        checkOutput("midrst_acc", 32'(out_acc), 32'd0);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 17'd1, 1'b0);
        checkOutput("midrst_out_valid", 32'(out_valid), 32'd1);
        checkOutput("midrst_out_acc",   32'(out_acc),   32'd4);
        checkOutput("midrst_out_ovf",   32'(out_ovf),   32'd0);
        applyStimulus(1'b0, 1'b0, 17'd0, 1'b1);

        // Reset while holding a result.
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 17'd100, 1'b0);
        checkOutput("holdrst_pre_valid", 32'(out_valid), 32'd1);
        reset = 1'b0;
        applyStimulus(1'b0, 1'b0, 17'd0, 1'b0);
        checkOutput("holdrst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("holdrst_in_ready",  32'(in_ready),  32'd1);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 17'd3, 1'b0);
        checkOutput("holdrst_next_acc", 32'(out_acc), 32'd12);
        applyStimulus(1'b0, 1'b0, 17'd0, 1'b1);

        // Overflow on the 18-bit accumulator: the third sample crosses 2^18-1.
        applyStimulus(1'b1, 1'b1, 17'd131071, 1'b0);
        applyStimulus(1'b1, 1'b1, 17'd131071, 1'b0);
        checkOutput("ovf18_no_ovf_yet", 32'(out_ovf18), 32'd0);
        applyStimulus(1'b1, 1'b1, 17'd131071, 1'b0);
        checkOutput("ovf18_mid_ovf", 32'(out_ovf18), 32'd1);
        checkOutput("ovf18_mid_acc", 32'(out_acc18), exp18_mid);
        applyStimulus(1'b1, 1'b1, 17'd131071, 1'b0);
        checkOutput("ovf18_out_valid", 32'(out_valid18), 32'd1);
        checkOutput("ovf18_out_acc",   32'(out_acc18),   exp18_final);
        checkOutput("ovf18_out_ovf",   32'(out_ovf18),   32'd1);
        applyStimulus(1'b1, 1'b0, 17'd0, 1'b1);
        checkOutput("ovf18_cleared_ovf", 32'(out_ovf18),  32'd0);
        checkOutput("ovf18_in_ready",    32'(in_ready18), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
